// File: rtl/alu_seq_unit.sv
// alu_seq_unit: sequential ALU with a valid/ready handshake, single-cycle logic ops and
// WIDTH-cycle iterative MUL/DIVU/REMU. Define ALU_SEQ_DIV_EN to build the divider.
module alu_seq_unit #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OpCode,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative,
    output logic             Err,
    output logic             Busy
);

    localparam int MSB = WIDTH - 1;
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_SAR  = 4'hA;
    localparam logic [3:0] OP_ROL  = 4'hB;
    localparam logic [3:0] OP_PASS = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_DIVU = 4'hE;
    localparam logic [3:0] OP_REMU = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_op;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;
    logic             r_neg;
    logic             r_err;

    logic             w_accept;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH:0]   w_wide;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_zero;
    logic             w_neg;
    logic             w_err;
    logic             w_iter;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_c;
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;
`endif

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign Busy      = (r_state == BUSY);
    assign Result    = r_result;
    assign Zero      = r_zero;
    assign Carry     = r_carry;
    assign Overflow  = r_ovf;
    assign Negative  = r_neg;
    assign Err       = r_err;
    assign w_amt     = B[SHW-1:0];

    // Result and flags for a request completing in one cycle, straight from the inputs.
    always_comb begin
        w_wide = '0;
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_err  = 1'b0;
        w_iter = 1'b0;
        case (OpCode)
            OP_ADD, OP_ADC: begin
                w_wide = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, (OpCode == OP_ADC) & Cin};
                w_res  = w_wide[MSB:0];
                w_c    = w_wide[WIDTH];
                w_v    = (A[MSB] == B[MSB]) && (w_res[MSB] != A[MSB]);
            end
            OP_SUB, OP_SBB: begin
                w_wide = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, (OpCode == OP_SBB) & Cin};
                w_res  = w_wide[MSB:0];
                w_c    = w_wide[WIDTH];
                w_v    = (A[MSB] != B[MSB]) && (w_res[MSB] != A[MSB]);
            end
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            OP_XOR:  w_res = A ^ B;
            OP_NOT:  w_res = ~A;
            // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
            OP_SHL: begin
                w_wide = {1'b0, A} << w_amt;
                w_res  = w_wide[MSB:0];
                w_c    = w_wide[WIDTH];
            end
            OP_SHR: begin
                w_wide = {A, 1'b0} >> w_amt;
                w_res  = w_wide[WIDTH:1];
                w_c    = w_wide[0];
            end
            OP_SAR: begin
                w_wide = $unsigned($signed({A, 1'b0}) >>> w_amt);
                w_res  = w_wide[WIDTH:1];
                w_c    = w_wide[0];
            end
            OP_ROL: begin
                w_res = (A << w_amt) | (A >> (WIDTH - int'(w_amt)));
                w_c   = (w_amt != '0) && w_res[0];
            end
            OP_PASS: w_res = A;
            OP_MUL:  w_iter = 1'b1;
            OP_DIVU, OP_REMU: begin
`ifdef ALU_SEQ_DIV_EN
                if (B == '0) begin
                    w_res = (OpCode == OP_DIVU) ? {WIDTH{1'b1}} : A;
                    w_err = 1'b1;
                end else begin
                    w_iter = 1'b1;
                end
`else
                w_res = '0;
                w_err = 1'b1;
`endif
            end
            default: w_res = '0;
        endcase
        w_zero = (w_res == '0);
        w_neg  = w_res[MSB];
`ifndef ALU_SEQ_DIV_EN
        if ((OpCode == OP_DIVU) || (OpCode == OP_REMU)) begin
            w_zero = 1'b0;
        end
`endif
    end

    // One iteration step: {r_hi,r_lo} is the running product, or the remainder/quotient pair.
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH + 1){1'b0}});
        w_step_hi = w_mul_sum[WIDTH:1];
        w_step_lo = {w_mul_sum[0], r_lo[MSB:1]};
        w_fin_res = w_step_lo;
`ifdef ALU_SEQ_DIV_EN
        w_div_shift = {r_hi, r_lo[MSB]};
        w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
        w_div_diff  = w_div_shift[MSB:0] - r_opnd;
        if (r_op != OP_MUL) begin
            w_step_hi = w_div_ge ? w_div_diff : w_div_shift[MSB:0];
            w_step_lo = {r_lo[MSB-1:0], w_div_ge};
            w_fin_res = (r_op == OP_REMU) ? w_step_hi : w_step_lo;
        end
`endif
        w_fin_c = (r_op == OP_MUL) && (w_step_hi != '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                BUSY: begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_state  <= DONE;
                        r_result <= w_fin_res;
                        r_zero   <= (w_fin_res == '0);
                        r_neg    <= w_fin_res[MSB];
                        r_carry  <= w_fin_c;
                        r_ovf    <= w_fin_c;
                        r_err    <= 1'b0;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_op  <= OpCode;
                        r_cnt <= '0;
                        if (w_iter) begin
                            r_state <= BUSY;
                            r_hi    <= '0;
                            r_lo    <= A;
                            r_opnd  <= B;
                        end else begin
                            r_state  <= DONE;
                            r_result <= w_res;
                            r_zero   <= w_zero;
                            r_neg    <= w_neg;
                            r_carry  <= w_c;
                            r_ovf    <= w_v;
                            r_err    <= w_err;
                        end
                    end else if ((r_state == DONE) && out_ready) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
